instruction_fetch_queue: RTL and testbench

INSTRUCTION_FETCH_QUEUE -- requirements
Module: instruction_fetch_queue

---
 rtl/instruction_fetch_queue_pkg.sv | 23 ++
 rtl/instruction_fetch_queue_fetch_fifo.sv | 69 ++++++
 rtl/instruction_fetch_queue.sv | 102 ++++++++++
 tb/tb_instruction_fetch_queue.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/instruction_fetch_queue_pkg.sv
// Shared CPU definitions used by the instruction fetch queue and its storage FIFO.
// Holds the XLEN, instruction size, NOP encoding and fetch-address helper functions.
package instruction_fetch_queue_pkg;

    localparam int XLEN       = 32;
    localparam int INSN_BYTES = 4;
    localparam logic [XLEN-1:0] NOP_INSN = 32'h0000_0013;

    // One queue entry: program counter in the upper half, instruction word in the lower half.
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] insn;
    } fetch_entry_t;

    function automatic logic [XLEN-1:0] align_insn_addr(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

    function automatic logic [XLEN-1:0] next_fetch_addr(input logic [XLEN-1:0] addr);
        return addr + XLEN'(INSN_BYTES);
    endfunction

endpackage

// File: rtl/instruction_fetch_queue_fetch_fifo.sv
// fetch_fifo: DEPTH x 64-bit circular buffer of {pc, instruction} entries.
// Supports push, pop and a single-cycle flush; the caller never pops an empty or overfills a full buffer.
module fetch_fifo
    import instruction_fetch_queue_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     push,
    input  logic [2*XLEN-1:0]        push_entry,
    input  logic                     pop,
    output logic [2*XLEN-1:0]        head_entry,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [PTR_W-1:0] PTR_ZERO = {PTR_W{1'b0}};
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [2*XLEN-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_r;
    logic [PTR_W-1:0]  rd_ptr_r;
    logic [CNT_W-1:0]  count_r;

    // Pointer and occupancy state; pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clock) begin
        if (!reset) begin
            wr_ptr_r <= PTR_ZERO;
            rd_ptr_r <= PTR_ZERO;
            count_r  <= CNT_ZERO;
        end else if (flush) begin
            wr_ptr_r <= PTR_ZERO;
            rd_ptr_r <= PTR_ZERO;
            count_r  <= CNT_ZERO;
        end else begin
            if (push) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            case ({push, pop})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    // Entry storage; when full with a simultaneous pop the write lands in the slot just consumed.
    always_ff @(posedge clock) begin
        if (reset && !flush && push) begin
            mem_r[wr_ptr_r] <= push_entry;
        end
    end

    assign head_entry = mem_r[rd_ptr_r];
    assign count      = count_r;

endmodule

// File: rtl/instruction_fetch_queue.sv
// Instruction fetch queue: fetches sequential words from a combinational ROM into a small FIFO.
// Optional macro FETCH_QUEUE_BYPASS_EN forwards the ROM word straight to the decoder when the queue is empty.
module instruction_fetch_queue
    import instruction_fetch_queue_pkg::*;
#(
    parameter int          DEPTH      = 4,
    parameter logic [31:0] RESET_ADDR = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    input  logic        redirect,
    input  logic [31:0] redirect_addr,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instruction,
    output logic [31:0] out_pc
);

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

    logic [XLEN-1:0]   fetch_pc_r;
    logic [CNT_W-1:0]  count_s;
    logic [2*XLEN-1:0] head_entry_s;
    logic [2*XLEN-1:0] push_entry_s;
    logic              head_valid_s;
    logic              bypass_s;
    logic              fifo_pop_s;
    logic              fetch_s;
    logic              fifo_push_s;

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fetch_fifo (
        .clock      (clock),
        .reset      (reset),
        .flush      (redirect),
        .push       (fifo_push_s),
        .push_entry (push_entry_s),
        .pop        (fifo_pop_s),
        .head_entry (head_entry_s),
        .count      (count_s)
    );

    // Queue control: a redirect suppresses both pop and push; fetch proceeds whenever a slot is or becomes free.
    always_comb begin
        head_valid_s = (count_s != CNT_ZERO) && !redirect;
`ifdef FETCH_QUEUE_BYPASS_EN
        bypass_s     = (count_s == CNT_ZERO) && !redirect;
`else
        bypass_s     = 1'b0;
`endif
        fifo_pop_s   = head_valid_s && out_ready;
        fetch_s      = !redirect && ((count_s != DEPTH_C) || fifo_pop_s);
        // A bypassed word the decoder accepts this cycle is consumed directly, never stored.
        fifo_push_s  = fetch_s && !(bypass_s && out_ready);
        push_entry_s = {fetch_pc_r, imem_data};
    end

    // Decoder-facing outputs, forced to zero whenever nothing is presented.
    always_comb begin
        out_valid       = 1'b0;
        out_pc          = 32'h0000_0000;
        out_instruction = 32'h0000_0000;
        if (head_valid_s) begin
            out_valid       = 1'b1;
            out_pc          = head_entry_s[2*XLEN-1:XLEN];
            out_instruction = head_entry_s[XLEN-1:0];
        end
`ifdef FETCH_QUEUE_BYPASS_EN
        else if (bypass_s) begin
            out_valid       = 1'b1;
            out_pc          = fetch_pc_r;
            out_instruction = imem_data;
        end
`endif
        else begin
            out_valid       = 1'b0;
            out_pc          = 32'h0000_0000;
            out_instruction = 32'h0000_0000;
        end
    end

    // Fetch program counter: reset wins over redirect, redirect wins over sequential advance.
    always_ff @(posedge clock) begin
        if (!reset) begin
            fetch_pc_r <= RESET_ADDR;
        end else if (redirect) begin
            fetch_pc_r <= align_insn_addr(redirect_addr);
        end else if (fetch_s) begin
            fetch_pc_r <= next_fetch_addr(fetch_pc_r);
        end else begin
            fetch_pc_r <= fetch_pc_r;
        end
    end

    assign imem_addr = fetch_pc_r;

endmodule

// File: tb/tb_instruction_fetch_queue.sv
// Self-checking bench for instruction_fetch_queue: queue-level reference model plus directed literal checks.
// Builds with or without FETCH_QUEUE_BYPASS_EN.
module tb_instruction_fetch_queue;

    localparam int          DEPTH      = 4;
    localparam logic [31:0] RESET_ADDR = 32'h0000_0000;
`ifdef FETCH_QUEUE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset;
    logic        redirect;
    logic        out_ready;
    logic [31:0] redirect_addr;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic        out_valid;
    logic [31:0] out_instruction;
    logic [31:0] out_pc;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: queue of {pc, insn} and the fetch address.
    logic [63:0] mq[$];
    logic [31:0] m_pc;
    bit          m_init = 1'b0;

    // Transition computed mid-cycle, applied at the following rising edge.
    bit          p_valid = 1'b0;
    bit          p_rst, p_redir, p_pop, p_push, p_adv;
    logic [31:0] p_raddr;

    always #5 clock = ~clock;

    function automatic logic [31:0] rom(input logic [31:0] a);
        return (a * 32'd3) ^ 32'hC0DE_0013;
    endfunction

    assign imem_data = rom(imem_addr);

    instruction_fetch_queue #(
        .DEPTH      (DEPTH),
        .RESET_ADDR (RESET_ADDR)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .imem_addr       (imem_addr),
        .imem_data       (imem_data),
        .redirect        (redirect),
        .redirect_addr   (redirect_addr),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_instruction (out_instruction),
        .out_pc          (out_pc)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %08h, expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic apply_model();
        if (p_valid) begin
            if (!p_rst) begin
                mq.delete();
                m_pc   = RESET_ADDR;
                m_init = 1'b1;
            end else if (m_init) begin
                if (p_redir) begin
                    mq.delete();
                    m_pc = {p_raddr[31:2], 2'b00};
                end else begin
                    if (p_pop) begin
                        void'(mq.pop_front());
                    end
                    if (p_push) begin
                        mq.push_back({m_pc, rom(m_pc)});
                    end
                    if (p_adv) begin
                        m_pc = m_pc + 32'd4;
                    end
                end
            end
        end
    endtask

    // One clock cycle: commit the model, drive inputs, compare outputs, plan the next transition.
    task automatic step(input logic rst, input logic rdy, input logic redir, input logic [31:0] raddr);
        int          n;
        bit          byp;
        bit          fetch_q;
        logic        ev;
        logic [31:0] epc;
        logic [31:0] ein;
        @(posedge clock);
        apply_model();
        @(negedge clock);
        reset         = rst;
        out_ready     = rdy;
        redirect      = redir;
        redirect_addr = raddr;
        #1;
        n   = mq.size();
        byp = BYP && (n == 0) && !redir;
        ev  = 1'b0;
        epc = 32'h0;
        ein = 32'h0;
        if (n > 0 && !redir) begin
            ev  = 1'b1;
            epc = mq[0][63:32];
            ein = mq[0][31:0];
        end else if (byp) begin
            ev  = 1'b1;
            epc = m_pc;
            ein = rom(m_pc);
        end
        if (m_init) begin
            check("model_out_valid", {31'h0, out_valid}, {31'h0, ev});
            check("model_out_pc", out_pc, epc);
            check("model_out_instruction", out_instruction, ein);
            check("model_imem_addr", imem_addr, m_pc);
        end
        fetch_q = !redir && ((n < DEPTH) || (n > 0 && rdy));
        p_valid = 1'b1;
        p_rst   = rst;
        p_redir = redir;
        p_raddr = raddr;
        p_pop   = (n > 0) && !redir && rdy;
        p_adv   = fetch_q;
        p_push  = fetch_q && !(byp && rdy);
    endtask

    initial begin
        reset         = 1'b0;
        out_ready     = 1'b0;
        redirect      = 1'b0;
        redirect_addr = 32'h0;

        // Reset release with the decoder always ready.
        step(1'b0, 1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b1, 1'b0, 32'h0);
        step(1'b1, 1'b1, 1'b0, 32'h0);
        check("first_cycle_valid", {31'h0, out_valid}, BYP ? 32'h1 : 32'h0);
        check("first_cycle_imem_addr", imem_addr, 32'h0000_0000);
        check("first_cycle_out_pc", out_pc, 32'h0000_0000);
        for (int k = 1; k <= 4; k++) begin
            step(1'b1, 1'b1, 1'b0, 32'h0);
            check("stream_out_valid", {31'h0, out_valid}, 32'h1);
            check("stream_out_pc", out_pc, BYP ? 32'(4 * k) : 32'(4 * (k - 1)));
            if (k == 1) begin
                check("stream_first_insn", out_instruction, BYP ? 32'hC0DE_001F : 32'hC0DE_0013);
            end
        end

        // Decoder stalled: the queue fills and fetch stops at 0x10.
        step(1'b0, 1'b0, 1'b0, 32'h0);
        for (int k = 0; k < 10; k++) begin
            step(1'b1, 1'b0, 1'b0, 32'h0);
        end
        check("full_imem_addr", imem_addr, 32'h0000_0010);
        check("full_out_pc", out_pc, 32'h0000_0000);
        check("full_out_valid", {31'h0, out_valid}, 32'h1);

        // One pop at full: one push from 0x10, occupancy unchanged.
        step(1'b1, 1'b1, 1'b0, 32'h0);
        check("full_pop_out_pc", out_pc, 32'h0000_0000);
        step(1'b1, 1'b0, 1'b0, 32'h0);
        check("after_pop_imem_addr", imem_addr, 32'h0000_0014);
        check("after_pop_out_pc", out_pc, 32'h0000_0004);
        step(1'b1, 1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b0, 1'b0, 32'h0);
        check("still_full_imem_addr", imem_addr, 32'h0000_0014);

        // Redirect to an unaligned target with three entries queued.
        step(1'b0, 1'b0, 1'b0, 32'h0);
        for (int k = 0; k < 3; k++) begin
            step(1'b1, 1'b0, 1'b0, 32'h0);
        end
        step(1'b1, 1'b1, 1'b1, 32'h0000_0103);
        check("redirect_out_valid", {31'h0, out_valid}, 32'h0);
        check("redirect_out_pc", out_pc, 32'h0000_0000);
        step(1'b1, 1'b1, 1'b0, 32'h0);
        check("post_redirect_imem_addr", imem_addr, 32'h0000_0100);
        check("post_redirect_out_pc", out_pc, BYP ? 32'h0000_0100 : 32'h0000_0000);
        step(1'b1, 1'b1, 1'b0, 32'h0);
        check("redirect_delivered_pc", out_pc, BYP ? 32'h0000_0104 : 32'h0000_0100);

        // Reset mid-stream together with a redirect: reset wins.
        step(1'b1, 1'b1, 1'b0, 32'h0);
        step(1'b1, 1'b1, 1'b0, 32'h0);
        step(1'b0, 1'b1, 1'b1, 32'h0000_0200);
        step(1'b1, 1'b0, 1'b0, 32'h0);
        check("reset_redirect_imem_addr", imem_addr, RESET_ADDR);
        check("reset_redirect_valid", {31'h0, out_valid}, BYP ? 32'h1 : 32'h0);
        check("reset_redirect_out_pc", out_pc, 32'h0000_0000);

        // Mixed traffic under the model: a slow decoder phase, then a fast one.
        for (int k = 0; k < 300; k++) begin
            logic rdy;
            logic rd;
            logic rs;
            rdy = (k < 150) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            rd  = ($urandom_range(0, 19) == 0);
            rs  = ($urandom_range(0, 99) != 0);
            step(rs, rdy, rd, $urandom);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
